// File: rtl/frog_player_ctrl.sv
// Player controller for the grid game: edge-triggered moves, goal/hazard handling,
// score and lives bookkeeping, timed death sequence and game-over hold.
module frog_player_ctrl #(
  parameter int GRID_W       = 20,
  parameter int GRID_H       = 15,
  parameter int COORD_W      = 6,
  parameter int START_X      = 10,
  parameter int START_Y      = 14,
  parameter int SCORE_W      = 7,
  parameter int LIVES        = 3,
  parameter int DEATH_CYCLES = 25_000_000
) (
  input  logic               i_Clk,
  input  logic               i_Reset,
  input  logic               i_Game_Active,
  input  logic               i_Up_Mvt,
  input  logic               i_Down_Mvt,
  input  logic               i_Left_Mvt,
  input  logic               i_Right_Mvt,
  input  logic               i_Hazard,
  input  logic [COORD_W-1:0] i_Col_Count_Div,
  input  logic [COORD_W-1:0] i_Row_Count_Div,
  output logic               o_Draw_Frogger,
  output logic [COORD_W-1:0] o_Frogger_X,
  output logic [COORD_W-1:0] o_Frogger_Y,
  output logic [SCORE_W-1:0] o_Score,
  output logic [2:0]         o_Lives,
  output logic               o_Score_Pulse,
  output logic               o_Death_Pulse,
  output logic               o_Game_Over
);

  localparam int CNT_W = (DEATH_CYCLES > 1) ? $clog2(DEATH_CYCLES) : 1;
  localparam logic [COORD_W-1:0] X0    = COORD_W'(START_X);
  localparam logic [COORD_W-1:0] Y0    = COORD_W'(START_Y);
  localparam logic [COORD_W-1:0] X_MAX = COORD_W'(GRID_W - 1);
  localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(GRID_H - 1);
  localparam logic [2:0]         L0    = 3'(LIVES);
  localparam logic [CNT_W-1:0]   D0    = CNT_W'(DEATH_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ALIVE, DYING, GAME_OVER} state_t;

  state_t           state;
  logic [3:0]       btn_prev;
  logic [3:0]       btn_now;
  logic [3:0]       btn_rise;
  logic [CNT_W-1:0] death_cnt;

  // Bit order {up, down, left, right}; higher bit wins when several rise together.
  assign btn_now  = {i_Up_Mvt, i_Down_Mvt, i_Left_Mvt, i_Right_Mvt};
  assign btn_rise = btn_now & ~btn_prev;

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state          <= IDLE;
      o_Frogger_X    <= X0;
      o_Frogger_Y    <= Y0;
      o_Score        <= '0;
      o_Lives        <= L0;
      o_Score_Pulse  <= 1'b0;
      o_Death_Pulse  <= 1'b0;
      o_Draw_Frogger <= 1'b0;
      o_Game_Over    <= 1'b0;
      btn_prev       <= '0;
      death_cnt      <= '0;
    end else begin
      btn_prev       <= btn_now;
      o_Score_Pulse  <= 1'b0;
      o_Death_Pulse  <= 1'b0;
      o_Draw_Frogger <= (state == ALIVE) && (i_Col_Count_Div == o_Frogger_X)
                        && (i_Row_Count_Div == o_Frogger_Y);
      if (!i_Game_Active) begin
        state       <= IDLE;
        o_Frogger_X <= X0;
        o_Frogger_Y <= Y0;
        o_Game_Over <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state       <= ALIVE;
            o_Score     <= '0;
            o_Lives     <= L0;
            o_Frogger_X <= X0;
            o_Frogger_Y <= Y0;
          end
          ALIVE: begin
            if (o_Frogger_Y == '0) begin
              if (o_Score != '1) o_Score <= o_Score + SCORE_W'(1);
              o_Score_Pulse <= 1'b1;
              o_Frogger_X   <= X0;
              o_Frogger_Y   <= Y0;
            end else if (i_Hazard) begin
              o_Lives       <= o_Lives - 3'd1;
              o_Death_Pulse <= 1'b1;
              death_cnt     <= D0;
              state         <= DYING;
            end else if (btn_rise[3]) begin
              o_Frogger_Y <= o_Frogger_Y - COORD_W'(1);
            end else if (btn_rise[2]) begin
              if (o_Frogger_Y != Y_MAX) o_Frogger_Y <= o_Frogger_Y + COORD_W'(1);
            end else if (btn_rise[1]) begin
              if (o_Frogger_X != '0) o_Frogger_X <= o_Frogger_X - COORD_W'(1);
            end else if (btn_rise[0]) begin
              if (o_Frogger_X != X_MAX) o_Frogger_X <= o_Frogger_X + COORD_W'(1);
            end
          end
          DYING: begin
            if (death_cnt == '0) begin
              if (o_Lives == 3'd0) begin
                state       <= GAME_OVER;
                o_Game_Over <= 1'b1;
              end else begin
                state       <= ALIVE;
                o_Frogger_X <= X0;
                o_Frogger_Y <= Y0;
              end
            end else begin
              death_cnt <= death_cnt - CNT_W'(1);
            end
          end
          GAME_OVER: begin
            o_Game_Over <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
